// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the add/shift multiplier control unit.
//   ctrl_state_t    : sequencing FSM states
//   N_STEPS_DEF     : default number of add/shift steps (operand width)
//   SYNC_STAGES_DEF : default button synchronizer depth
//   step_width()    : width of the step counter for a given step count
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADB,
        CLEAR,
        SHIFT,
        DONE
    } ctrl_state_t;

    localparam int unsigned N_STEPS_DEF     = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Guard against a zero-width counter if someone asks for a single step.
    function automatic int unsigned step_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiplier_control_unit_if.sv
// Button-in / strobe-out bundle between the board front end and the multiplier control unit.
//   Run, ClearA_LoadB : active-high button levels, asynchronous to the clock
//   ClrA_LdB, ClrA    : one-cycle datapath strobes
//   Shift, F          : add/shift step enable and final (subtract) step flag
//   Busy, Done        : status LEDs
//   Step              : current step index, 0 outside the shift phase
// master: the button front end / observer.  slave: the control unit.
interface multiplier_control_unit_if #(
    parameter int unsigned N_STEPS = mult_ctrl_pkg::N_STEPS_DEF
) ();

    localparam int unsigned StepW = mult_ctrl_pkg::step_width(N_STEPS);

    logic             Run;
    logic             ClearA_LoadB;
    logic             ClrA_LdB;
    logic             ClrA;
    logic             Shift;
    logic             F;
    logic             Busy;
    logic             Done;
    logic [StepW-1:0] Step;

    modport master (
        output Run,
        output ClearA_LoadB,
        input  ClrA_LdB,
        input  ClrA,
        input  Shift,
        input  F,
        input  Busy,
        input  Done,
        input  Step
    );

    modport slave (
        input  Run,
        input  ClearA_LoadB,
        output ClrA_LdB,
        output ClrA,
        output Shift,
        output F,
        output Busy,
        output Done,
        output Step
    );

endinterface

// File: rtl/button_sync.sv
// Multi-flop synchronizer for one asynchronous button level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears the whole chain
//   d_i    : asynchronous input level
//   q_o    : synchronized level, SYNC_STAGES cycles behind d_i
module button_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/multiplier_control_unit.sv
// Sequencing FSM for the 8-bit add/shift multiplier datapath.
// Converts the Run and ClearA_LoadB buttons into datapath strobes and status LEDs.
//   Clk     : single clock, all state on the rising edge
//   Reset_n : asynchronous active-low reset; forces IDLE and all outputs low
//   bus_io  : button inputs and strobe/status outputs (slave side of the interface)
// Outputs are registered copies of the decode of the next state, so they always
// equal the decode of the current state with no input-to-output combinational path.
module multiplier_control_unit
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned N_STEPS     = N_STEPS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    multiplier_control_unit_if.slave bus_io
);

    localparam int unsigned      StepW    = step_width(N_STEPS);
    localparam logic [StepW-1:0] LastStep = StepW'(N_STEPS - 1);

    // Synchronized button levels
    logic run_s;
    logic clr_s;

    button_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_run_sync (
        .clk_i (Clk),
        .rst_ni(Reset_n),
        .d_i   (bus_io.Run),
        .q_o   (run_s)
    );

    button_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_clr_sync (
        .clk_i (Clk),
        .rst_ni(Reset_n),
        .d_i   (bus_io.ClearA_LoadB),
        .q_o   (clr_s)
    );

    ctrl_state_t      state_q, state_d;
    logic [StepW-1:0] cnt_q, cnt_d;
    logic             clr_prev_q;
    logic             clr_edge;

    logic             ld_q, ld_d;
    logic             clra_q, clra_d;
    logic             shift_q, shift_d;
    logic             f_q, f_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [StepW-1:0] step_q, step_d;

    // The previous-value register tracks clr_s in every state, so a press that
    // arrives while busy is consumed there and never becomes a LOADB later.
    assign clr_edge = clr_s & ~clr_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // LOADB wins a tie; Run is level-held so CLEAR follows from IDLE.
                if (clr_edge) begin
                    state_d = LOADB;
                end else if (run_s) begin
                    state_d = CLEAR;
                end
            end
            LOADB: begin
                state_d = IDLE;
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q != LastStep) begin
                    cnt_d = cnt_q + StepW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Wait for Run release so a held button yields one multiply.
                if (!run_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ld_d    = (state_d == LOADB);
        clra_d  = (state_d == CLEAR);
        shift_d = (state_d == SHIFT);
        f_d     = shift_d && (cnt_d == LastStep);
        busy_d  = clra_d || shift_d;
        done_d  = (state_d == DONE);
        step_d  = shift_d ? cnt_d : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_prev_q <= 1'b0;
            ld_q       <= 1'b0;
            clra_q     <= 1'b0;
            shift_q    <= 1'b0;
            f_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_prev_q <= clr_s;
            ld_q       <= ld_d;
            clra_q     <= clra_d;
            shift_q    <= shift_d;
            f_q        <= f_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            step_q     <= step_d;
        end
    end

    assign bus_io.ClrA_LdB = ld_q;
    assign bus_io.ClrA     = clra_q;
    assign bus_io.Shift    = shift_q;
    assign bus_io.F        = f_q;
    assign bus_io.Busy     = busy_q;
    assign bus_io.Done     = done_q;
    assign bus_io.Step     = step_q;

endmodule

// File: tb/tb_multiplier_control_unit.sv
// Scoreboard bench: an 8-step and a 4-step control unit share clock and reset.
// Each Run press pushes the expected multiply profile; a monitor pops and compares
// it when Done rises.
module tb_multiplier_control_unit;
    import mult_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiplier_control_unit_if #(.N_STEPS(8)) ifc8 ();
    multiplier_control_unit_if #(.N_STEPS(4)) ifc4 ();

    multiplier_control_unit #(
        .N_STEPS    (8),
        .SYNC_STAGES(2)
    ) u_dut8 (
        .Clk    (clk),
        .Reset_n(rst_n),
        .bus_io (ifc8)
    );

    multiplier_control_unit #(
        .N_STEPS    (4),
        .SYNC_STAGES(2)
    ) u_dut4 (
        .Clk    (clk),
        .Reset_n(rst_n),
        .bus_io (ifc4)
    );

    typedef struct {
        int shifts;
        int busy;
        int fstep;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-DUT monitor state, index 0 = 8-step unit, 1 = 4-step unit
    int ld_cnt[2];
    int clra_cnt[2];
    int sh_cnt[2];
    int cur_sh[2];
    int cur_busy[2];
    int cur_f[2];
    int cur_fstep[2];
    int ld_cyc[2];
    int clra_cyc[2];
    bit done_prev[2];

    task automatic mon(input int i, input logic ld, input logic clra, input logic sh,
                       input logic f, input logic busy, input logic done, input int step);
        exp_t e;
        if (ld) begin
            ld_cnt[i]++;
            ld_cyc[i] = cyc;
        end
        if (clra) begin
            clra_cnt[i]++;
            clra_cyc[i]  = cyc;
            cur_sh[i]    = 0;
            cur_busy[i]  = 0;
            cur_f[i]     = 0;
            cur_fstep[i] = -1;
        end
        if (busy) cur_busy[i]++;
        if (sh) begin
            check_eq($sformatf("step_seq%0d", i), step, cur_sh[i]);
            cur_sh[i]++;
            sh_cnt[i]++;
            if (f) begin
                cur_f[i]++;
                cur_fstep[i] = step;
            end
        end else begin
            check_eq($sformatf("step_idle%0d", i), step, 0);
            check_eq($sformatf("f_idle%0d", i), int'(f), 0);
        end
        if (done && !done_prev[i]) begin
            if ((i == 0 && q8.size() == 0) || (i == 1 && q4.size() == 0)) begin
                check_eq($sformatf("sb_unexpected_done%0d", i), 1, 0);
            end else begin
                e = (i == 0) ? q8.pop_front() : q4.pop_front();
                check_eq($sformatf("sb_shifts%0d", i), cur_sh[i], e.shifts);
                check_eq($sformatf("sb_busy%0d", i), cur_busy[i], e.busy);
                check_eq($sformatf("sb_fcount%0d", i), cur_f[i], 1);
                check_eq($sformatf("sb_fstep%0d", i), cur_fstep[i], e.fstep);
            end
        end
        done_prev[i] = done;
    endtask

    always @(negedge clk) begin
        mon(0, ifc8.ClrA_LdB, ifc8.ClrA, ifc8.Shift, ifc8.F, ifc8.Busy, ifc8.Done,
            int'(ifc8.Step));
        mon(1, ifc4.ClrA_LdB, ifc4.ClrA, ifc4.Shift, ifc4.F, ifc4.Busy, ifc4.Done,
            int'(ifc4.Step));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic done_of(input int i);
        return (i == 0) ? ifc8.Done : ifc4.Done;
    endfunction

    task automatic wait_done(input int i, input logic want, input int budget);
        bit hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            tick(1);
            if (done_of(i) == want) hit = 1;
        end
        if (!hit) check_eq($sformatf("done_timeout%0d", i), int'(done_of(i)), int'(want));
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ld"},    int'(ifc8.ClrA_LdB), 0);
        check_eq({tag, "_clra"},  int'(ifc8.ClrA), 0);
        check_eq({tag, "_shift"}, int'(ifc8.Shift), 0);
        check_eq({tag, "_f"},     int'(ifc8.F), 0);
        check_eq({tag, "_busy"},  int'(ifc8.Busy), 0);
        check_eq({tag, "_done"},  int'(ifc8.Done), 0);
        check_eq({tag, "_step"},  int'(ifc8.Step), 0);
        check_eq({tag, "_dut4"},  int'({ifc4.ClrA_LdB, ifc4.ClrA, ifc4.Shift, ifc4.F,
                                        ifc4.Busy, ifc4.Done, ifc4.Step}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        int   ld0, clra0, sh0;
        bit   hit;
        exp_t e8;
        exp_t e4;

        e8 = '{shifts: 8, busy: 9, fstep: 7};
        e4 = '{shifts: 4, busy: 5, fstep: 3};

        rst_n             = 1'b0;
        ifc8.Run          = 1'b0;
        ifc8.ClearA_LoadB = 1'b0;
        ifc4.Run          = 1'b0;
        ifc4.ClearA_LoadB = 1'b0;
        tick(2);
        check_quiet("reset");
        rst_n = 1'b1;
        tick(3);

        // Reset asserted mid-multiply at Step 3
        ifc8.Run = 1'b1;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            tick(1);
            if (ifc8.Shift && ifc8.Step == 3'd3) hit = 1;
        end
        check_eq("reach_step3", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        ifc8.Run = 1'b0;
        tick(2);
        rst_n = 1'b1;
        sh0 = sh_cnt[0];
        tick(10);
        check_eq("post_reset_shift", sh_cnt[0] - sh0, 0);
        check_eq("post_reset_done", int'(ifc8.Done), 0);

        // Held Run: one multiply, Done held until release, no retrigger
        clra0 = clra_cnt[0];
        sh0   = sh_cnt[0];
        ifc8.Run = 1'b1;
        t0 = cyc;
        q8.push_back(e8);
        wait_done(0, 1'b1, 40);
        check_eq("clra_latency", clra_cyc[0] - t0, 3);
        tick(15);
        check_eq("done_held", int'(ifc8.Done), 1);
        check_eq("held_clra_count", clra_cnt[0] - clra0, 1);
        check_eq("held_shift_count", sh_cnt[0] - sh0, 8);
        ifc8.Run = 1'b0;
        wait_done(0, 1'b0, 10);
        tick(3);
        check_eq("held_shift_after", sh_cnt[0] - sh0, 8);

        // ClearA_LoadB held 20 cycles in IDLE
        ld0   = ld_cnt[0];
        clra0 = clra_cnt[0];
        sh0   = sh_cnt[0];
        ifc8.ClearA_LoadB = 1'b1;
        tick(20);
        ifc8.ClearA_LoadB = 1'b0;
        tick(5);
        check_eq("loadb_pulses", ld_cnt[0] - ld0, 1);
        check_eq("loadb_no_clra", clra_cnt[0] - clra0, 0);
        check_eq("loadb_no_shift", sh_cnt[0] - sh0, 0);

        // Run and ClearA_LoadB rising together
        ld0   = ld_cnt[0];
        clra0 = clra_cnt[0];
        ifc8.Run          = 1'b1;
        ifc8.ClearA_LoadB = 1'b1;
        q8.push_back(e8);
        wait_done(0, 1'b1, 40);
        check_eq("tie_ld_count", ld_cnt[0] - ld0, 1);
        check_eq("tie_clra_count", clra_cnt[0] - clra0, 1);
        check_eq("tie_ld_first", int'(ld_cyc[0] < clra_cyc[0]), 1);
        ifc8.Run          = 1'b0;
        ifc8.ClearA_LoadB = 1'b0;
        wait_done(0, 1'b0, 10);
        tick(3);

        // Button activity during SHIFT is ignored
        ld0   = ld_cnt[0];
        clra0 = clra_cnt[0];
        sh0   = sh_cnt[0];
        ifc8.Run = 1'b1;
        q8.push_back(e8);
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            tick(1);
            if (ifc8.Shift) hit = 1;
        end
        check_eq("reach_shift", int'(hit), 1);
        for (int k = 0; k < 4; k++) begin
            ifc8.ClearA_LoadB = (k % 2 == 0);
            ifc8.Run          = (k % 2 == 1);
            tick(1);
        end
        ifc8.Run          = 1'b0;
        ifc8.ClearA_LoadB = 1'b0;
        wait_done(0, 1'b1, 20);
        wait_done(0, 1'b0, 10);
        tick(5);
        check_eq("toggle_no_ld", ld_cnt[0] - ld0, 0);
        check_eq("toggle_clra", clra_cnt[0] - clra0, 1);
        check_eq("toggle_shifts", sh_cnt[0] - sh0, 8);

        // 4-step instance
        sh0 = sh_cnt[1];
        ifc4.Run = 1'b1;
        t0 = cyc;
        q4.push_back(e4);
        wait_done(1, 1'b1, 30);
        check_eq("n4_clra_latency", clra_cyc[1] - t0, 3);
        ifc4.Run = 1'b0;
        wait_done(1, 1'b0, 10);
        tick(3);
        check_eq("n4_shift_total", sh_cnt[1] - sh0, 4);

        check_eq("sb8_left", q8.size(), 0);
        check_eq("sb4_left", q4.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
